pixel_pair_packer: RTL and testbench

- Stage directly upstream of the splicer.
- Accepts a single-pixel AXI4-Stream video feed and packs two consecutive pixels into one 2*PIXEL_WIDTH beat, which is the pixel-pair format the splicer consumes.
- Regenerates clean SOF (tuser) and EOL (tlast) from line and frame counters.
- Repairs short lines, long lines and misplaced SOF, and reports each with an error pulse.

---
 rtl/pixel_pair_packer.sv | 196 +++++++++++++++++++
 tb/tb_pixel_pair_packer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_pair_packer.sv
// Packs two consecutive AXI4-Stream pixels into one beat with regenerated SOF/EOL; beat valid 1 cycle after the odd pixel.
// Single output register; s_axis_tready = !m_axis_tvalid || m_axis_tready, so input stalls only while the register is stalled.
module pixel_pair_packer #(
    parameter int PIXEL_WIDTH  = 24,
    parameter int FRAME_WIDTH  = 10,
    parameter int FRAME_HEIGHT = 10
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [PIXEL_WIDTH-1:0]   s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    output logic [2*PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    output logic                     err_short_line,
    output logic                     err_long_line,
    output logic                     err_sof
);
    localparam int XW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
    localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

    typedef enum logic [1:0] {WAIT_SOF, LO, HI, DISCARD} state_t;

    state_t                   state_q, state_d;
    logic [XW-1:0]            x_q, x_d;
    logic [YW-1:0]            y_q, y_d;
    logic [PIXEL_WIDTH-1:0]   even_q, even_d;
    logic                     sof_pending_q, sof_pending_d;
    logic [2*PIXEL_WIDTH-1:0] tdata_q, tdata_d;
    logic                     tvalid_q, tvalid_d;
    logic                     tuser_q, tuser_d;
    logic                     tlast_q, tlast_d;
    logic                     err_short_q, err_short_d;
    logic                     err_long_q, err_long_d;
    logic                     err_sof_q, err_sof_d;

    logic in_rdy;
    logic accept;
    logic emit;
    logic emit_pair;
    logic emit_last;
    logic end_line;
    logic set_short;
    logic set_long;
    logic set_sof;

    assign in_rdy = aresetn && (!tvalid_q || m_axis_tready);
    assign accept = s_axis_tvalid && in_rdy;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= WAIT_SOF;
            x_q           <= '0;
            y_q           <= '0;
            even_q        <= '0;
            sof_pending_q <= 1'b0;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            tuser_q       <= 1'b0;
            tlast_q       <= 1'b0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            err_sof_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            even_q        <= even_d;
            sof_pending_q <= sof_pending_d;
            tdata_q       <= tdata_d;
            tvalid_q      <= tvalid_d;
            tuser_q       <= tuser_d;
            tlast_q       <= tlast_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
            err_sof_q     <= err_sof_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        even_d        = even_q;
        sof_pending_d = sof_pending_q;
        emit          = 1'b0;
        emit_pair     = 1'b0;
        emit_last     = 1'b0;
        end_line      = 1'b0;
        set_short     = 1'b0;
        set_long      = 1'b0;
        set_sof       = 1'b0;
        if (accept) begin
            if (s_axis_tuser) begin
                // Any SOF restarts the frame; a held even pixel is dropped.
                set_sof       = (state_q != WAIT_SOF);
                even_d        = s_axis_tdata;
                sof_pending_d = 1'b1;
                x_d           = XW'(1);
                y_d           = '0;
                state_d       = HI;
            end else begin
                unique case (state_q)
                    WAIT_SOF: ;
                    LO: begin
                        even_d  = s_axis_tdata;
                        x_d     = x_q + 1'b1;
                        state_d = HI;
                        if (s_axis_tlast) begin
                            emit      = 1'b1;
                            emit_last = 1'b1;
                            set_short = 1'b1;
                            end_line  = 1'b1;
                        end
                    end
                    HI: begin
                        emit      = 1'b1;
                        emit_pair = 1'b1;
                        if (x_q == X_LAST) begin
                            emit_last = 1'b1;
                            if (s_axis_tlast) begin
                                end_line = 1'b1;
                            end else begin
                                set_long = 1'b1;
                                state_d  = DISCARD;
                            end
                        end else if (s_axis_tlast) begin
                            emit_last = 1'b1;
                            set_short = 1'b1;
                            end_line  = 1'b1;
                        end else begin
                            x_d     = x_q + 1'b1;
                            state_d = LO;
                        end
                    end
                    DISCARD: begin
                        if (s_axis_tlast) begin
                            end_line = 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (end_line) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        y_d     = '0;
                        state_d = WAIT_SOF;
                    end else begin
                        y_d     = y_q + 1'b1;
                        state_d = LO;
                    end
                end
                if (emit) begin
                    sof_pending_d = 1'b0;
                end
            end
        end
    end

    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
        // A new beat can only load when the register is empty or draining.
        if (emit) begin
            tvalid_d = 1'b1;
            tdata_d  = emit_pair ? {s_axis_tdata, even_q}
                                 : {{PIXEL_WIDTH{1'b0}}, s_axis_tdata};
            tuser_d  = sof_pending_q;
            tlast_d  = emit_last;
        end
        err_short_d = set_short;
        err_long_d  = set_long;
        err_sof_d   = set_sof;
    end

    assign s_axis_tready  = in_rdy;
    assign m_axis_tdata   = tdata_q;
    assign m_axis_tvalid  = tvalid_q;
    assign m_axis_tuser   = tuser_q;
    assign m_axis_tlast   = tlast_q;
    assign err_short_line = err_short_q;
    assign err_long_line  = err_long_q;
    assign err_sof        = err_sof_q;
endmodule

// File: tb/tb_pixel_pair_packer.sv
// Randomized line/frame stimulus against a line-level reference model; a monitor pops expected beats on every output handshake.
module tb_pixel_pair_packer;
    localparam int PW = 24;
    localparam int FW = 10;
    localparam int FH = 10;

    typedef struct packed {
        logic [2*PW-1:0] dat;
        logic            user;
        logic            last;
    } beat_t;

    typedef struct packed {
        logic [PW-1:0] dat;
        logic          user;
        logic          last;
    } pix_t;

    logic            clk;
    logic            aresetn;
    logic [PW-1:0]   s_dat;
    logic            s_vld;
    logic            s_rdy;
    logic            s_user;
    logic            s_last;
    logic [2*PW-1:0] m_dat;
    logic            m_vld;
    logic            m_rdy;
    logic            m_user;
    logic            m_last;
    logic            e_short;
    logic            e_long;
    logic            e_sof;

    pixel_pair_packer #(.PIXEL_WIDTH(PW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH)) dut (
        .aclk(clk), .aresetn(aresetn),
        .s_axis_tdata(s_dat), .s_axis_tvalid(s_vld), .s_axis_tready(s_rdy),
        .s_axis_tuser(s_user), .s_axis_tlast(s_last),
        .m_axis_tdata(m_dat), .m_axis_tvalid(m_vld), .m_axis_tready(m_rdy),
        .m_axis_tuser(m_user), .m_axis_tlast(m_last),
        .err_short_line(e_short), .err_long_line(e_long), .err_sof(e_sof)
    );

    pix_t  stim_q[$];
    beat_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int n_beats = 0;
    int exp_short = 0, exp_long = 0, exp_sof = 0;
    int got_short = 0, got_long = 0, got_sof = 0;
    int rdy_mode = 0;
    int y = 0;
    bit in_frame = 0;
    bit seq_mode = 0;
    logic [PW-1:0] seq = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output-side ready pattern: 0 always ready, 1 random, 2 toggling.
    initial begin
        m_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_rdy = 1'b1;
                1:       m_rdy = ($urandom_range(0, 1) == 1);
                default: m_rdy = ~m_rdy;
            endcase
        end
    end

    function automatic logic [PW-1:0] next_pix();
        logic [PW-1:0] v;
        if (seq_mode) begin
            v   = seq;
            seq = seq + 1'b1;
        end else begin
            v = PW'($urandom);
        end
        return v;
    endfunction

    function automatic int rand_len(input int min_len);
        if ($urandom_range(0, 9) < 6) return FW;
        return int'($urandom_range(min_len, FW + 3));
    endfunction

    // One complete line of L pixels: the first min(L,FW) pixels are paired, the rest vanish.
    task automatic gen_line(input int len, input bit sof);
        logic [PW-1:0] p[$];
        pix_t  s;
        beat_t b;
        int    n;
        for (int i = 0; i < len; i++) begin
            s.dat  = next_pix();
            s.user = sof && (i == 0);
            s.last = (i == len - 1);
            p.push_back(s.dat);
            stim_q.push_back(s);
        end
        n = (len < FW) ? len : FW;
        for (int j = 0; 2 * j < n; j++) begin
            b.dat[PW-1:0]    = p[2*j];
            b.dat[2*PW-1:PW] = (2 * j + 1 < n) ? p[2*j+1] : '0;
            b.user           = sof && (j == 0);
            b.last           = (2 * j + 2 >= n);
            exp_q.push_back(b);
        end
        if (len < FW) exp_short++;
        else if (len > FW) exp_long++;
        y++;
        if (y == FH) in_frame = 0;
    endtask

    task automatic gen_frame_start(input int len);
        if (in_frame) exp_sof++;
        in_frame = 1;
        y        = 0;
        gen_line(len, 1'b1);
    endtask

    // A line cut short after k pixels by a new SOF; only complete pairs survive.
    task automatic gen_abort(input int k, input int len);
        logic [PW-1:0] p[$];
        pix_t  s;
        beat_t b;
        for (int i = 0; i < k; i++) begin
            s.dat  = next_pix();
            s.user = 1'b0;
            s.last = 1'b0;
            p.push_back(s.dat);
            stim_q.push_back(s);
        end
        for (int j = 0; 2 * j + 1 < k; j++) begin
            b.dat  = {p[2*j+1], p[2*j]};
            b.user = 1'b0;
            b.last = 1'b0;
            exp_q.push_back(b);
        end
        gen_frame_start(len);
    endtask

    task automatic gen_junk(input int k);
        pix_t s;
        for (int i = 0; i < k; i++) begin
            s.dat  = next_pix();
            s.user = 1'b0;
            s.last = ($urandom_range(0, 3) == 0);
            stim_q.push_back(s);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the last pixel is accepted.
    task automatic run_stim(input int gap_pct);
        int guard;
        bit fire;
        guard = 0;
        while (stim_q.size() > 0) begin
            if (!s_vld && int'($urandom_range(0, 99)) >= gap_pct) begin
                s_dat  = stim_q[0].dat;
                s_user = stim_q[0].user;
                s_last = stim_q[0].last;
                s_vld  = 1'b1;
            end
            @(negedge clk);
            fire = s_vld && s_rdy;
            @(posedge clk);
            #1;
            if (fire) begin
                void'(stim_q.pop_front());
                s_vld = 1'b0;
            end
            guard++;
            if (guard > 40000) begin
                errors++;
                $display("FAIL input_timeout: %0d pixels left, required 0", stim_q.size());
                stim_q.delete();
                s_vld = 1'b0;
            end
        end
        s_vld = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats still expected, required 0", exp_q.size());
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    // Monitor: beat scoreboard, stall stability, error pulse counting.
    initial begin
        beat_t cur, prev, e;
        bit    prev_stall;
        prev_stall = 0;
        prev       = '0;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                prev_stall = 0;
            end else begin
                cur = {m_dat, m_user, m_last};
                if (prev_stall) begin
                    checks++;
                    if (m_vld !== 1'b1 || cur !== prev) begin
                        errors++;
                        $display("FAIL stall_hold: got vld=%b %h, required vld=1 %h", m_vld, cur, prev);
                    end
                end
                if (m_vld && !m_rdy) begin
                    checks++;
                    if (s_rdy !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_ready: s_axis_tready=%b, required 0", s_rdy);
                    end
                end
                if (m_vld && m_rdy) begin
                    n_beats++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat_unexpected: got %h, required no beat", cur);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            errors++;
                            $display("FAIL beat: got dat=%h user=%b last=%b, required dat=%h user=%b last=%b",
                                     cur.dat, cur.user, cur.last, e.dat, e.user, e.last);
                        end
                    end
                end
                if (e_short) got_short++;
                if (e_long)  got_long++;
                if (e_sof)   got_sof++;
                prev_stall = m_vld && !m_rdy;
                prev       = cur;
            end
        end
    end

    initial begin
        int beats_before;
        pix_t s;
        beat_t b;
        aresetn = 1'b0;
        s_vld   = 1'b0;
        s_dat   = '0;
        s_user  = 1'b0;
        s_last  = 1'b0;
        #2;
        check_bit("reset_s_tready", s_rdy, 1'b0);
        check_bit("reset_m_tvalid", m_vld, 1'b0);
        check_bit("reset_errs", e_short | e_long | e_sof, 1'b0);
        checks++;
        if (m_dat !== '0 || m_user !== 1'b0 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_m_data: got %h/%b/%b, required 0", m_dat, m_user, m_last);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;

        // Random frames with short/long lines, leading junk and mid-frame SOF.
        for (int seg = 0; seg < 250; seg++) begin
            if (!in_frame) begin
                gen_junk(int'($urandom_range(0, 5)));
                gen_frame_start(rand_len(2));
            end else if ($urandom_range(0, 9) == 0) begin
                gen_abort(int'($urandom_range(0, FW - 1)), rand_len(2));
            end else begin
                gen_line(rand_len(1), 1'b0);
            end
        end
        rdy_mode = 1;
        run_stim(30);
        wait_drain();

        // Reset with one even pixel held after a completed pair.
        rdy_mode = 0;
        if (in_frame) exp_sof++;
        for (int i = 0; i < 3; i++) begin
            s.dat  = PW'($urandom);
            s.user = (i == 0);
            s.last = 1'b0;
            stim_q.push_back(s);
        end
        b.dat  = {stim_q[1].dat, stim_q[0].dat};
        b.user = 1'b1;
        b.last = 1'b0;
        exp_q.push_back(b);
        run_stim(0);
        @(negedge clk);
        @(posedge clk);
        #1;
        check_bit("pre_reset_s_tready", s_rdy, 1'b1);
        aresetn = 1'b0;
        #1;
        check_bit("midreset_s_tready", s_rdy, 1'b0);
        check_bit("midreset_m_tvalid", m_vld, 1'b0);
        checks++;
        if (m_dat !== '0 || m_user !== 1'b0 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL midreset_m_data: got %h/%b/%b, required 0", m_dat, m_user, m_last);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn  = 1'b1;
        in_frame = 0;
        y        = 0;
        @(posedge clk);
        #1;
        wait_drain();

        // Pixels without SOF after reset must produce nothing.
        beats_before = n_beats;
        rdy_mode     = 2;
        gen_junk(20);
        run_stim(0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (n_beats != beats_before) begin
            errors++;
            $display("FAIL no_beats_before_sof: got %0d beats, required 0", n_beats - beats_before);
        end

        // Nominal counting frame under toggling backpressure.
        seq_mode = 1;
        seq      = '0;
        gen_junk(5);
        seq = '0;
        gen_frame_start(FW);
        for (int l = 1; l < FH; l++) gen_line(FW, 1'b0);
        run_stim(0);
        wait_drain();
        repeat (4) @(posedge clk);
        #1;

        checks++;
        if (got_short != exp_short) begin
            errors++;
            $display("FAIL err_short_count: got %0d, required %0d", got_short, exp_short);
        end
        checks++;
        if (got_long != exp_long) begin
            errors++;
            $display("FAIL err_long_count: got %0d, required %0d", got_long, exp_long);
        end
        checks++;
        if (got_sof != exp_sof) begin
            errors++;
            $display("FAIL err_sof_count: got %0d, required %0d", got_sof, exp_sof);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
